alu4_nibble_sequencer: RTL and testbench

- Multi-cycle controller that runs the team's 4-bit ALU slice nibble-serially to perform W-bit operations, where W = 4*NIB.
- Latches a wide operation on a start pulse, then drives the 4-bit ALU one nibble per clock, least significant nibble first. For arithmetic operations it threads the ALU carry between nibbles through a register.
- Assembles the wide result and reports completion with a one-cycle done pulse.
- Sits between a simple command source (CPU-style control FSM or testbench) and a single 4-bit ALU instance, which lives outside this block.

---
 rtl/alu4_nibble_sequencer.sv | 170 +++++++++++++++++
 tb/tb_alu4_nibble_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu4_nibble_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu4_nibble_sequencer
// Purpose  : Runs an external 4-bit ALU slice one nibble per clock, least
//            significant nibble first, to perform a 4*NIB-bit operation.
//            Carry is threaded between nibbles through a register; the wide
//            result is assembled locally and completion is a 1-cycle pulse.
// Revision : 1.0 - initial release
// ============================================================================
module alu4_nibble_sequencer #(
  parameter int NIB = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic               ci,
  input  logic [4*NIB-1:0]   a,
  input  logic [4*NIB-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [4*NIB-1:0]   result,
  output logic               co,
  output logic               zero,
  output logic               alu_s2,
  output logic               alu_s1,
  output logic               alu_s0,
  output logic               alu_cin,
  output logic [3:0]         alu_a,
  output logic [3:0]         alu_b,
  input  logic               alu_cout,
  input  logic [3:0]         alu_g
);

  localparam int W  = 4 * NIB;
  // Nibble index width; a single-nibble build still needs a 1-bit index.
  localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;

  logic [2:0]     op_r;
  logic           ci_r;
  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic [IW-1:0]  idx;
  logic           carry_r;

  logic [3:0]     nib_a;
  logic [3:0]     nib_b;
  logic [W-1:0]   result_nxt;

  // Select the current operand nibbles and merge the ALU result nibble into
  // the partially assembled word (constant-index loop keeps slices in range).
  always_comb begin
    nib_a      = '0;
    nib_b      = '0;
    result_nxt = result;
    for (int i = 0; i < NIB; i++) begin
      if (idx == IW'(i)) begin
        nib_a               = a_r[i*4 +: 4];
        nib_b               = b_r[i*4 +: 4];
        result_nxt[i*4 +: 4] = alu_g;
      end
    end
  end

  // Next-state decode plus handshake and ALU drive; ALU lines rest at 0
  // outside RUN.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    alu_s2    = 1'b0;
    alu_s1    = 1'b0;
    alu_s0    = 1'b0;
    alu_cin   = 1'b0;
    alu_a     = 4'd0;
    alu_b     = 4'd0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy                     = 1'b1;
        {alu_s2, alu_s1, alu_s0} = op_r;
        alu_a                    = nib_a;
        alu_b                    = nib_b;
        // Logic ops never take a carry; arithmetic uses ci only on nibble 0.
        if (!op_r[2]) begin
          alu_cin = (idx == '0) ? ci_r : carry_r;
        end
        if (idx == LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Command latch, nibble stepping, carry thread and result/flag assembly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r    <= 3'd0;
      ci_r    <= 1'b0;
      a_r     <= '0;
      b_r     <= '0;
      idx     <= '0;
      carry_r <= 1'b0;
      result  <= '0;
      co      <= 1'b0;
      zero    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_r    <= op;
            ci_r    <= ci;
            a_r     <= a;
            b_r     <= b;
            idx     <= '0;
            carry_r <= 1'b0;
            result  <= '0;
          end
        end
        RUN: begin
          result  <= result_nxt;
          carry_r <= alu_cout;
          if (idx == LAST) begin
            // Flags only change here, so they stay stable through RUN.
            idx  <= '0;
            co   <= ~op_r[2] & alu_cout;
            zero <= (result_nxt == '0);
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu4_nibble_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu4_nibble_sequencer
// Purpose  : Directed and randomized checks of the nibble sequencer for
//            NIB = 1, 2 and 4, each instance paired with a behavioural ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu4_nibble_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic        ci;
  logic [15:0] a16;
  logic [15:0] b16;

  int total  = 0;
  int passed = 0;

  // Per-instance signals (suffix = NIB).
  logic        busy1, done1, co1, zero1, cin1, cout1;
  logic [3:0]  res1;
  logic [2:0]  s1;
  logic [3:0]  aa1, ab1, g1;
  logic        busy2, done2, co2, zero2, cin2, cout2;
  logic [7:0]  res2;
  logic [2:0]  s2;
  logic [3:0]  aa2, ab2, g2;
  logic        busy4, done4, co4, zero4, cin4, cout4;
  logic [15:0] res4;
  logic [2:0]  s4;
  logic [3:0]  aa4, ab4, g4;

  // Behavioural 4-bit ALU slice: {cout, g}.
  function automatic logic [4:0] alu_nib(input logic [2:0] s, input logic cin,
                                         input logic [3:0] x, input logic [3:0] y);
    case (s)
      3'd0:    return {1'b0, x} + 5'(cin);
      3'd1:    return {1'b0, x} + {1'b0, y} + 5'(cin);
      3'd2:    return {1'b0, x} + {1'b0, ~y} + 5'(cin);
      3'd3:    return {1'b0, x} + 5'd15 + 5'(cin);
      3'd4:    return {1'b0, x & y};
      3'd5:    return {1'b0, x | y};
      3'd6:    return {1'b0, x ^ y};
      default: return {1'b0, ~x};
    endcase
  endfunction

  // Wide reference: {co, result} for a 4*nib-bit operation.
  function automatic logic [32:0] ref_op(input logic [2:0] o, input logic c,
                                         input logic [31:0] x, input logic [31:0] y,
                                         input int nib);
    logic [63:0] m, s, xa, ya;
    m  = (64'd1 << (4 * nib)) - 64'd1;
    xa = {32'd0, x} & m;
    ya = {32'd0, y} & m;
    case (o)
      3'd0:    s = xa + 64'(c);
      3'd1:    s = xa + ya + 64'(c);
      3'd2:    s = xa + (~ya & m) + 64'(c);
      3'd3:    s = xa + m + 64'(c);
      3'd4:    s = xa & ya;
      3'd5:    s = xa | ya;
      3'd6:    s = xa ^ ya;
      default: s = ~xa & m;
    endcase
    return {s[4 * nib], s[31:0] & m[31:0]};
  endfunction

  assign {cout1, g1} = alu_nib(s1, cin1, aa1, ab1);
  assign {cout2, g2} = alu_nib(s2, cin2, aa2, ab2);
  assign {cout4, g4} = alu_nib(s4, cin4, aa4, ab4);

  alu4_nibble_sequencer #(.NIB(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .op(op), .ci(ci),
    .a(a16[3:0]), .b(b16[3:0]), .busy(busy1), .done(done1), .result(res1),
    .co(co1), .zero(zero1), .alu_s2(s1[2]), .alu_s1(s1[1]), .alu_s0(s1[0]),
    .alu_cin(cin1), .alu_a(aa1), .alu_b(ab1), .alu_cout(cout1), .alu_g(g1)
  );

  alu4_nibble_sequencer #(.NIB(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .op(op), .ci(ci),
    .a(a16[7:0]), .b(b16[7:0]), .busy(busy2), .done(done2), .result(res2),
    .co(co2), .zero(zero2), .alu_s2(s2[2]), .alu_s1(s2[1]), .alu_s0(s2[0]),
    .alu_cin(cin2), .alu_a(aa2), .alu_b(ab2), .alu_cout(cout2), .alu_g(g2)
  );

  alu4_nibble_sequencer #(.NIB(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .op(op), .ci(ci),
    .a(a16), .b(b16), .busy(busy4), .done(done4), .result(res4),
    .co(co4), .zero(zero4), .alu_s2(s4[2]), .alu_s1(s4[1]), .alu_s0(s4[0]),
    .alu_cin(cin4), .alu_a(aa4), .alu_b(ab4), .alu_cout(cout4), .alu_g(g4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Issue one op on all instances, then scramble the inputs; records the
  // NIB=4 latency (edges after the start edge) and its per-nibble alu_cin.
  task automatic run_op(input logic [2:0] o, input logic c, input logic [15:0] x,
                        input logic [15:0] y, output int lat, output logic [3:0] cins);
    op = o; ci = c; a16 = x; b16 = y; start = 1'b1;
    tick;
    start = 1'b0;
    op = ~o; ci = ~c; a16 = ~x; b16 = 16'($urandom);
    lat  = 0;
    cins = '0;
    while (done4 !== 1'b1 && lat < 20) begin
      if (lat < 4) cins[lat[1:0]] = cin4;
      tick;
      lat++;
    end
    tick;
    chk("done_single_pulse", 32'(done4), 32'(0));
    chk("idle_alu_zero", 32'({s4, cin4, aa4, ab4}), 32'(0));
  endtask

  initial begin
    int          lat;
    int          n;
    logic [3:0]  cins;
    logic [2:0]  eop;
    logic        eci;
    logic [15:0] ea, eb;
    logic [32:0] e1, e2, e4;

    rst = 1'b1; start = 1'b0; op = 3'd0; ci = 1'b0; a16 = '0; b16 = '0;
    tick; tick;
    rst = 1'b0;
    tick;
    chk("rst_busy", 32'(busy4), 32'(0));
    chk("rst_done", 32'(done4), 32'(0));
    chk("rst_result", 32'(res4), 32'(0));
    chk("rst_co", 32'(co4), 32'(0));
    chk("rst_zero", 32'(zero4), 32'(1));
    chk("rst_alu", 32'({s4, cin4, aa4, ab4}), 32'(0));

    // Wide add
    run_op(3'b001, 1'b0, 16'h1234, 16'h0FCD, lat, cins);
    chk("add_latency", lat, 4);
    chk("add_result", 32'(res4), 32'h2201);
    chk("add_co", 32'(co4), 32'(0));
    chk("add_zero", 32'(zero4), 32'(0));

    // Subtract with borrow, then without
    run_op(3'b010, 1'b1, 16'h0005, 16'h0007, lat, cins);
    chk("sub1_result", 32'(res4), 32'hFFFE);
    chk("sub1_co", 32'(co4), 32'(0));
    run_op(3'b010, 1'b1, 16'h8000, 16'h0001, lat, cins);
    chk("sub2_result", 32'(res4), 32'h7FFF);
    chk("sub2_co", 32'(co4), 32'(1));

    // Increment: full wrap, then carry chain dying after nibble 1
    run_op(3'b000, 1'b1, 16'hFFFF, 16'h0000, lat, cins);
    chk("inc_wrap_result", 32'(res4), 32'h0000);
    chk("inc_wrap_co", 32'(co4), 32'(1));
    chk("inc_wrap_zero", 32'(zero4), 32'(1));
    chk("inc_wrap_cins", 32'(cins), 32'(4'b1111));
    run_op(3'b000, 1'b1, 16'h0F0F, 16'h0000, lat, cins);
    chk("inc_chain_result", 32'(res4), 32'h0F10);
    chk("inc_chain_cins", 32'(cins), 32'(4'b0011));
    chk("inc_chain_zero", 32'(zero4), 32'(0));

    // Logic ops ignore ci
    run_op(3'b110, 1'b1, 16'hF0F0, 16'hFFFF, lat, cins);
    chk("xor_result", 32'(res4), 32'h0F0F);
    chk("xor_co", 32'(co4), 32'(0));
    chk("xor_cins", 32'(cins), 32'(0));
    run_op(3'b111, 1'b1, 16'h0000, 16'h1234, lat, cins);
    chk("not_result", 32'(res4), 32'hFFFF);
    chk("not_cins", 32'(cins), 32'(0));

    // Start pulsed during RUN cycle 2 must be ignored
    op = 3'b001; ci = 1'b0; a16 = 16'h0001; b16 = 16'h0001; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    start = 1'b1; op = 3'b110; a16 = 16'hFFFF;
    tick;
    start = 1'b0;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      if (done4 === 1'b1) n++;
      tick;
    end
    chk("ignore_done_count", n, 1);
    chk("ignore_result", 32'(res4), 32'h0002);

    // Asynchronous reset during RUN cycle 2
    op = 3'b001; ci = 1'b0; a16 = 16'h1111; b16 = 16'h0000; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    chk("pre_rst_partial", 32'(res4), 32'h0001);
    chk("pre_rst_zero_held", 32'(zero4), 32'(0));
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy4), 32'(0));
    chk("mid_rst_result", 32'(res4), 32'(0));
    chk("mid_rst_zero", 32'(zero4), 32'(1));
    chk("mid_rst_done", 32'(done4), 32'(0));
    tick;
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      if (done4 === 1'b1) n++;
      tick;
    end
    chk("post_rst_no_done", n, 0);

    // Randomized ops on NIB = 1, 2, 4 concurrently
    for (int it = 0; it < 1000; it++) begin
      eop = 3'($urandom_range(0, 7));
      eci = 1'($urandom_range(0, 1));
      ea  = 16'($urandom);
      eb  = 16'($urandom);
      op = eop; ci = eci; a16 = ea; b16 = eb; start = 1'b1;
      tick;
      start = 1'b0;
      op = 3'($urandom); ci = ~eci; a16 = 16'($urandom); b16 = 16'($urandom);
      for (int k = 1; k <= 5; k++) begin
        tick;
        chk("rnd_done1", 32'(done1), 32'(k == 1));
        chk("rnd_done2", 32'(done2), 32'(k == 2));
        chk("rnd_done4", 32'(done4), 32'(k == 4));
      end
      e1 = ref_op(eop, eci, 32'(ea), 32'(eb), 1);
      e2 = ref_op(eop, eci, 32'(ea), 32'(eb), 2);
      e4 = ref_op(eop, eci, 32'(ea), 32'(eb), 4);
      chk("rnd_res1", 32'(res1), e1[31:0]);
      chk("rnd_co1", 32'(co1), 32'(e1[32]));
      chk("rnd_zero1", 32'(zero1), 32'(e1[31:0] == 32'd0));
      chk("rnd_res2", 32'(res2), e2[31:0]);
      chk("rnd_co2", 32'(co2), 32'(e2[32]));
      chk("rnd_zero2", 32'(zero2), 32'(e2[31:0] == 32'd0));
      chk("rnd_res4", 32'(res4), e4[31:0]);
      chk("rnd_co4", 32'(co4), 32'(e4[32]));
      chk("rnd_zero4", 32'(zero4), 32'(e4[31:0] == 32'd0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
